mem_data_port: RTL
==================

Name: mem_data_port

Overview:
- Consumes the memory-request fields the EX/MEM register presents to the M stage (M_mem_en/ren/wen/op/addr/wdata) and acts as the data-side responder toward the data cache/bus.
- Generates the sram-like request, the byte strobes and the aligned write data, tracks the transaction, and stalls the pipeline until completion.
- Returns extracted, sign- or zero-extended load data to the M stage.
- Handles flushes that arrive mid-transaction by retiring the outstanding response.

Parameters:
- none; widths are fixed by the 32-bit MIPS datapath.

Ports:
- clk  input  1  clock; sole clock.
- rst  input  1  reset; synchronous, active-high.
- M_mem_en  input  1  M stage holds a memory instruction.
- M_mem_ren  input  1  load.
- M_mem_wen  input  1  store.
- M_mem_op  input  6  access type; encodings in cpu_defs_pkg.
- M_mem_addr  input  32  physical address.
- M_mem_wdata  input  32  store data, unaligned (low bits).
- M_cancel  input  1  M-stage instruction carries an exception; suppresses issue.
- flush  input  1  pipeline flush (exception/eret at commit).
- stall_other  input  1  M stage held by another cause this cycle.
- mem_stall  output  1  hold the pipeline at and before M.
- M_mem_rdata  output  32  extended load result, valid when mem_stall=0.
- data_req  output  1  request valid.
- data_wr  output  1  1 = write.
- data_size  output  2  0 byte, 1 half, 2 word.
- data_addr  output  32  request address.
- data_wstrb  output  4  byte enables.
- data_wdata  output  32  aligned write data.
- data_addr_ok  input  1  request accepted.
- data_data_ok  input  1  response/write ack.
- data_rdata  input  32  read data, word-aligned.

Behaviour:
- States: IDLE, WAIT_ADDR, WAIT_DATA, DONE, DISCARD. Reset sets IDLE and clears all request latches, rdata latch and op/offset latches to 0.
- Outputs under rst: data_req=0, mem_stall=0, M_mem_rdata=0.
- Issue condition: issue = IDLE & M_mem_en & ~M_cancel & ~flush.
- In IDLE, request fields are driven combinationally from the M inputs and latched at the same edge.
- In WAIT_ADDR, the latched fields are driven.
- data_req = issue | WAIT_ADDR. Once asserted, a request is never retracted before data_addr_ok.
- Transitions:
  - IDLE: issue & addr_ok -> WAIT_DATA; issue & ~addr_ok -> WAIT_ADDR.
  - WAIT_ADDR: addr_ok -> WAIT_DATA, or DISCARD if flush was seen while in WAIT_ADDR (sticky bit).
  - WAIT_DATA: data_ok & stall_other & ~flush -> DONE; data_ok otherwise -> IDLE; flush & ~data_ok -> DISCARD.
  - DONE: ~stall_other | flush -> IDLE.
  - DISCARD: data_ok -> IDLE.
- data_data_ok is ignored in IDLE and WAIT_ADDR. At most one transaction is outstanding; no request may issue before the prior data_ok.
- mem_stall = (IDLE & M_mem_en & ~M_cancel & ~flush) | WAIT_ADDR | (WAIT_DATA & ~data_ok) | DISCARD.
- The DISCARD term blocks the post-flush instruction until the old response drains.
- Store alignment uses off = addr[1:0]:
  - SB: wstrb = 1<<off, wdata = {4{wdata[7:0]}}.
  - SH: wstrb = off[1] ? 1100 : 0011, wdata = {2{wdata[15:0]}}.
  - SW: wstrb = 1111, wdata unchanged.
  - Loads drive wstrb = 0000.
- data_addr is the full address; the slave ignores bits [1:0] for word accesses.
- Load extraction: shifted = data_rdata >> (8*off), then:
  - LB sign-extends shifted[7:0]; LBU zero-extends shifted[7:0].
  - LH sign-extends shifted[15:0]; LHU zero-extends shifted[15:0].
  - LW passes shifted through.
- op and off come from the latched copy.
- M_mem_rdata is combinational from data_rdata in the WAIT_DATA & data_ok cycle, and from the registered extended value in DONE. It is 0 otherwise.
- Misaligned addresses never reach this block unflagged: the upstream AdEL/AdES check sets M_cancel.
- Reset mid-transaction returns to IDLE at once; the bus side is reset together with the block.

Decomposition:
- cpu_defs_pkg holds the mem_op encodings: MEM_LB=6'd1, MEM_LBU=6'd2, MEM_LH=6'd3, MEM_LHU=6'd4, MEM_LW=6'd5, MEM_SB=6'd6, MEM_SH=6'd7, MEM_SW=6'd8.
- cpu_defs_pkg also holds the mdp_state_t enum and the size constants.
- One combinational sub-module, mem_align, provides store strobe/data generation and load extraction; the FSM stays in mem_data_port.

Test Plan:
- SW addr=0x1000_0004, wdata=0xDEADBEEF, addr_ok same cycle, data_ok next cycle -> data_req 1 cycle, wstrb=1111, wr=1, size=2, mem_stall high exactly 1 cycle.
- LB addr=...02, rdata=0x0080_0000, addr_ok after 3 cycles -> req held 4 cycles with stable fields, M_mem_rdata=0xFFFF_FF80; same with LBU -> 0x0000_0080.
- SH addr=...02, wdata=0x1234 -> wstrb=1100, data_wdata=0x1234_1234, size=1.
- LW with data_ok while stall_other=1 for 2 more cycles -> state DONE, mem_stall=0, M_mem_rdata stable at the rdata value, return to IDLE when stall_other drops.
- flush in WAIT_DATA, new LW on M inputs, data_ok 2 cycles later -> DISCARD, no data_req and mem_stall=1 until data_ok; new LW issues the cycle after.
- M_cancel=1 with a store pending -> no data_req, mem_stall=0; rst asserted in WAIT_DATA -> IDLE next cycle, all outputs 0.

Source files
------------

// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the data-side memory port: mem_op encodings,
// bus size codes and the port FSM state type.
package cpu_defs_pkg;

  localparam logic [5:0] MEM_LB  = 6'd1;
  localparam logic [5:0] MEM_LBU = 6'd2;
  localparam logic [5:0] MEM_LH  = 6'd3;
  localparam logic [5:0] MEM_LHU = 6'd4;
  localparam logic [5:0] MEM_LW  = 6'd5;
  localparam logic [5:0] MEM_SB  = 6'd6;
  localparam logic [5:0] MEM_SH  = 6'd7;
  localparam logic [5:0] MEM_SW  = 6'd8;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [2:0] {
    MDP_IDLE,
    MDP_WAIT_ADDR,
    MDP_WAIT_DATA,
    MDP_DONE,
    MDP_DISCARD
  } mdp_state_t;

  function automatic logic [1:0] op_size(input logic [5:0] op);
    case (op)
      MEM_LB, MEM_LBU, MEM_SB: op_size = SIZE_BYTE;
      MEM_LH, MEM_LHU, MEM_SH: op_size = SIZE_HALF;
      default:                 op_size = SIZE_WORD;
    endcase
  endfunction

endpackage

// File: rtl/mem_data_port_if.sv
// sram-like data bus between the M-stage port (master) and the data cache (slave).
interface mem_data_port_if;
  // Handshake: data_req with its fields stays asserted and stable until the cycle
  // data_addr_ok is high (accept); data_data_ok later marks read data / write ack,
  // with at most one accepted request outstanding.
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/mem_align.sv
// Combinational byte-lane logic: store strobes/replicated write data and
// load byte/half extraction with sign or zero extension.
module mem_align
  import cpu_defs_pkg::*;
(
  input  logic [5:0]  st_op,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  input  logic [5:0]  ld_op,
  input  logic [1:0]  ld_off,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] ld_data
);

  logic [31:0] shifted;

  always_comb begin
    wstrb = 4'b0000;
    wdata = st_data;
    case (st_op)
      MEM_SB: begin
        wstrb = 4'b0001 << st_off;
        wdata = {4{st_data[7:0]}};
      end
      MEM_SH: begin
        wstrb = st_off[1] ? 4'b1100 : 4'b0011;
        wdata = {2{st_data[15:0]}};
      end
      MEM_SW: wstrb = 4'b1111;
      default: ;
    endcase
  end

  // Read data arrives word-aligned; bring the addressed lane down to bit 0.
  assign shifted = rdata >> {ld_off, 3'b000};

  always_comb begin
    ld_data = shifted;
    case (ld_op)
      MEM_LB:  ld_data = {{24{shifted[7]}}, shifted[7:0]};
      MEM_LBU: ld_data = {24'd0, shifted[7:0]};
      MEM_LH:  ld_data = {{16{shifted[15]}}, shifted[15:0]};
      MEM_LHU: ld_data = {16'd0, shifted[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_data_port.sv
// M-stage data port: issues one sram-like request per memory instruction,
// stalls the pipeline until it completes and returns extended load data.
module mem_data_port
  import cpu_defs_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        M_mem_en,
  input  logic        M_mem_ren,
  input  logic        M_mem_wen,
  input  logic [5:0]  M_mem_op,
  input  logic [31:0] M_mem_addr,
  input  logic [31:0] M_mem_wdata,
  input  logic        M_cancel,
  input  logic        flush,
  input  logic        stall_other,
  output logic        mem_stall,
  output logic [31:0] M_mem_rdata,
  mem_data_port_if.master bus,
  output mdp_state_t  dbg_state
);

  mdp_state_t  state_q, state_d;
  logic        issue, capture, flush_seen_q;
  logic        wr_q, ren_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0]  wstrb_q;
  logic [5:0]  op_q;
  logic [3:0]  st_wstrb;
  logic [31:0] st_wdata, ld_data;

  mem_align u_align (
    .st_op   (M_mem_op),
    .st_off  (M_mem_addr[1:0]),
    .st_data (M_mem_wdata),
    .ld_op   (op_q),
    .ld_off  (addr_q[1:0]),
    .rdata   (bus.data_rdata),
    .wstrb   (st_wstrb),
    .wdata   (st_wdata),
    .ld_data (ld_data)
  );

  assign issue   = (state_q == MDP_IDLE) & M_mem_en & ~M_cancel & ~flush;
  assign capture = (state_q == MDP_WAIT_DATA) & bus.data_data_ok & stall_other & ~flush;
  assign dbg_state = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= MDP_IDLE;
      flush_seen_q <= 1'b0;
      wr_q         <= 1'b0;
      ren_q        <= 1'b0;
      size_q       <= 2'd0;
      addr_q       <= 32'd0;
      wstrb_q      <= 4'd0;
      wdata_q      <= 32'd0;
      op_q         <= 6'd0;
      rdata_q      <= 32'd0;
    end else begin
      state_q <= state_d;
      // A flush seen while the request waits for accept must still drain its response.
      flush_seen_q <= (state_q == MDP_WAIT_ADDR) & ~bus.data_addr_ok & (flush_seen_q | flush);
      if (issue) begin
        wr_q    <= M_mem_wen;
        ren_q   <= M_mem_ren;
        size_q  <= op_size(M_mem_op);
        addr_q  <= M_mem_addr;
        wstrb_q <= st_wstrb;
        wdata_q <= st_wdata;
        op_q    <= M_mem_op;
      end
      if (capture) rdata_q <= ld_data;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MDP_IDLE:
        if (issue) state_d = bus.data_addr_ok ? MDP_WAIT_DATA : MDP_WAIT_ADDR;
      MDP_WAIT_ADDR:
        if (bus.data_addr_ok) state_d = (flush_seen_q | flush) ? MDP_DISCARD : MDP_WAIT_DATA;
      MDP_WAIT_DATA:
        if (bus.data_data_ok) state_d = (stall_other & ~flush) ? MDP_DONE : MDP_IDLE;
        else if (flush)       state_d = MDP_DISCARD;
      MDP_DONE:
        if (~stall_other | flush) state_d = MDP_IDLE;
      MDP_DISCARD:
        if (bus.data_data_ok) state_d = MDP_IDLE;
      default: state_d = MDP_IDLE;
    endcase
  end

  always_comb begin
    bus.data_req   = ~rst & (issue | (state_q == MDP_WAIT_ADDR));
    bus.data_wr    = (state_q == MDP_IDLE) ? M_mem_wen          : wr_q;
    bus.data_size  = (state_q == MDP_IDLE) ? op_size(M_mem_op)  : size_q;
    bus.data_addr  = (state_q == MDP_IDLE) ? M_mem_addr         : addr_q;
    bus.data_wstrb = (state_q == MDP_IDLE) ? st_wstrb           : wstrb_q;
    bus.data_wdata = (state_q == MDP_IDLE) ? st_wdata           : wdata_q;
    mem_stall = ~rst & (issue | (state_q == MDP_WAIT_ADDR) |
                        ((state_q == MDP_WAIT_DATA) & ~bus.data_data_ok) |
                        (state_q == MDP_DISCARD));
    M_mem_rdata = 32'd0;
    if (~rst & ren_q) begin
      if ((state_q == MDP_WAIT_DATA) & bus.data_data_ok) M_mem_rdata = ld_data;
      else if (state_q == MDP_DONE)                     M_mem_rdata = rdata_q;
    end
  end

endmodule
